// File: rtl/fwrisc_irq_pkg.sv
// Shared constants and types for the fwrisc interrupt controller:
// register map, CLAIM layout and bus handshake states.
package fwrisc_irq_pkg;

  localparam int MAX_IRQ = 32;
  localparam int BUS_W   = 32;

  localparam logic [2:0] REG_PENDING = 3'd0;
  localparam logic [2:0] REG_ENABLE  = 3'd1;
  localparam logic [2:0] REG_MODE    = 3'd2;
  localparam logic [2:0] REG_CLAIM   = 3'd3;

  localparam int CLAIM_ID_W      = 5;
  localparam int CLAIM_FOUND_BIT = 5;

  typedef struct packed {
    logic                  found;
    logic [CLAIM_ID_W-1:0] id;
  } claim_t;

  typedef enum logic {
    BUS_IDLE = 1'b0,
    BUS_ACK  = 1'b1
  } bus_state_e;

  function automatic logic [BUS_W-1:0] strb_mask(input logic [3:0] strb);
    logic [BUS_W-1:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{strb[i]}};
    return m;
  endfunction

endpackage

// File: rtl/fwrisc_irq_ctrl_if.sv
// fwrisc data-bus slave port (dvalid/dready) used to program the interrupt controller.
interface fwrisc_irq_ctrl_if;
  import fwrisc_irq_pkg::*;

  logic             dvalid;
  logic [BUS_W-1:0] daddr;
  logic [BUS_W-1:0] dwdata;
  logic [3:0]       dwstb;
  logic             dwrite;
  logic [BUS_W-1:0] drdata;
  logic             dready;

  modport master (output dvalid, daddr, dwdata, dwstb, dwrite, input  drdata, dready);
  modport slave  (input  dvalid, daddr, dwdata, dwstb, dwrite, output drdata, dready);
endinterface

// File: rtl/fwrisc_irq_sync.sv
// WIDTH x STAGES flop chain bringing asynchronous interrupt lines into the clock domain.
module fwrisc_irq_sync #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] sync_q, sync_d;

  always_comb sync_d = {sync_q[STAGES-2:0], d};

  always_ff @(posedge clock) begin
    if (reset) sync_q <= '0;
    else       sync_q <= sync_d;
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/fwrisc_irq_ctrl.sv
// Interrupt controller for the fwrisc core: N_IRQ level/edge sources with enables,
// memory-mapped config over the dvalid/dready bus and a lowest-index-wins CLAIM register.
module fwrisc_irq_ctrl
  import fwrisc_irq_pkg::*;
#(
  parameter int                 N_IRQ        = 8,
  parameter int                 SYNC_STAGES  = 2,
  parameter logic [MAX_IRQ-1:0] DEFAULT_MODE = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [N_IRQ-1:0]      irq_src,
  fwrisc_irq_ctrl_if.slave      bus,
  output logic                  irq,
  output logic [CLAIM_ID_W-1:0] irq_id
);

  bus_state_e            state_q, state_d;
  logic                  access, rd, wr;
  logic [2:0]            reg_idx;
  logic [N_IRQ-1:0]      s, s_q, s_d, s_prev_q, s_prev_d;
  logic [N_IRQ-1:0]      pending_q, pending_d, enable_q, enable_d, mode_q, mode_d;
  logic [N_IRQ-1:0]      clr, edge_evt;
  logic                  irq_q, irq_d;
  logic [CLAIM_ID_W-1:0] irq_id_q, irq_id_d;
  logic [BUS_W-1:0]      drdata_q, drdata_d, rdata;
  logic [BUS_W-1:0]      wmask, wbits, pend_w, en_w, mode_w, en_new, mode_new;
  claim_t                claim;
  logic                  unused_bits;

  function automatic claim_t prio(input logic [N_IRQ-1:0] v);
    claim_t c;
    c = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (v[i]) begin
        c.found = 1'b1;
        c.id    = CLAIM_ID_W'(i);
      end
    end
    return c;
  endfunction

  for (genvar i = 0; i < N_IRQ; i++) begin : g_sync
    fwrisc_irq_sync #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_sync (
      .clock (clock),
      .reset (reset),
      .d     (irq_src[i]),
      .q     (s[i])
    );
  end

  // One request per IDLE visit; the ACK cycle always returns to IDLE so a
  // still-asserted dvalid is not accepted twice.
  always_comb begin
    state_d = state_q;
    access  = 1'b0;
    case (state_q)
      BUS_IDLE: if (bus.dvalid) begin
        access  = 1'b1;
        state_d = BUS_ACK;
      end
      BUS_ACK:  state_d = BUS_IDLE;
      default:  state_d = BUS_IDLE;
    endcase
  end

  always_comb begin
    rd      = access & ~bus.dwrite;
    wr      = access &  bus.dwrite;
    reg_idx = bus.daddr[4:2];
    wmask   = strb_mask(bus.dwstb);
    wbits   = bus.dwdata & wmask;
    pend_w  = '0;
    en_w    = '0;
    mode_w  = '0;
    pend_w[N_IRQ-1:0] = pending_q;
    en_w[N_IRQ-1:0]   = enable_q;
    mode_w[N_IRQ-1:0] = mode_q;
    en_new   = (en_w   & ~wmask) | wbits;
    mode_new = (mode_w & ~wmask) | wbits;
    claim    = prio(pending_q & enable_q);

    rdata = '0;
    case (reg_idx)
      REG_PENDING: rdata = pend_w;
      REG_ENABLE:  rdata = en_w;
      REG_MODE:    rdata = mode_w;
      REG_CLAIM: begin
        rdata[CLAIM_FOUND_BIT]  = claim.found;
        rdata[CLAIM_ID_W-1:0]   = claim.id;
      end
      default: rdata = '0;
    endcase

    clr = '0;
    if (wr && reg_idx == REG_PENDING) clr = wbits[N_IRQ-1:0];
    if (rd && reg_idx == REG_CLAIM) begin
      for (int i = 0; i < N_IRQ; i++)
        if (claim.found && claim.id == CLAIM_ID_W'(i)) clr[i] = 1'b1;
    end

    // Edge sources: a new edge overrides a same-cycle clear; level sources follow the line.
    edge_evt  = s_q & ~s_prev_q;
    pending_d = (mode_q & (edge_evt | (pending_q & ~clr))) | (~mode_q & s_q);

    enable_d = enable_q;
    mode_d   = mode_q;
    if (wr && reg_idx == REG_ENABLE) enable_d = en_new[N_IRQ-1:0];
    if (wr && reg_idx == REG_MODE)   mode_d   = mode_new[N_IRQ-1:0];

    // s is retimed once more so PENDING lands SYNC_STAGES+1 edges after the first sample.
    s_d      = s;
    s_prev_d = s_q;
    irq_d    = claim.found;
    irq_id_d = claim.id;
    drdata_d = rd ? rdata : '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= BUS_IDLE;
      pending_q <= '0;
      enable_q  <= '0;
      mode_q    <= DEFAULT_MODE[N_IRQ-1:0];
      s_q       <= '0;
      s_prev_q  <= '0;
      irq_q     <= 1'b0;
      irq_id_q  <= '0;
      drdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      enable_q  <= enable_d;
      mode_q    <= mode_d;
      s_q       <= s_d;
      s_prev_q  <= s_prev_d;
      irq_q     <= irq_d;
      irq_id_q  <= irq_id_d;
      drdata_q  <= drdata_d;
    end
  end

  assign bus.drdata = drdata_q;
  assign bus.dready = (state_q == BUS_ACK);
  assign irq        = irq_q;
  assign irq_id     = irq_id_q;

  assign unused_bits = ^{bus.daddr, en_new, mode_new, wbits};

endmodule
